// File: rtl/sha_word_streamer_pkg.sv
// rtl/sha_word_streamer_pkg.sv - shared types and defaults for the SHA word streamer
package sha_stream_pkg;

    typedef enum logic {ST_STREAM, ST_FILL} stream_state_e;

    localparam int DEFAULT_DATA_W      = 64;
    localparam int DEFAULT_BLOCK_WORDS = 512 / DEFAULT_DATA_W;

endpackage

// File: rtl/sha_word_streamer_if.sv
// rtl/sha_word_streamer_if.sv - input and output word streams of the SHA word streamer
interface sha_word_streamer_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_first;
    logic              out_blk_last;
    logic              out_msg_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_blk_last, out_msg_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_first, out_blk_last, out_msg_last
    );
endinterface

// File: rtl/sha_word_streamer_fifo.sv
// rtl/sha_word_streamer_fifo.sv - first-word-fall-through synchronous FIFO with occupancy output
module sha_sync_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/sha_word_streamer.sv
// rtl/sha_word_streamer.sv - frames buffered message words into zero-filled SHA blocks
module sha_word_streamer
    import sha_stream_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int DEPTH       = 8,
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int CNT_W       = 32,
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sha_word_streamer_if.slave s,
    output logic [LVL_W-1:0] level,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] blk_cnt
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_WORDS - 1);

    stream_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

    logic              full, empty, push, pop, xfer, idx_last, out_valid;
    logic [DATA_W:0]   head;
    logic              head_last;
    logic [DATA_W-1:0] head_data;

    assign s.in_ready = rst_n && !full;
    assign push       = s.in_valid && s.in_ready;
    assign {head_last, head_data} = head;
    assign idx_last   = (idx_q == IDX_LAST);

    sha_sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({s.in_last, s.in_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (level)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        word_cnt_d     = word_cnt_q;
        blk_cnt_d      = blk_cnt_q;
        out_valid      = 1'b0;
        s.out_data     = '0;
        s.out_msg_last = 1'b0;
        case (state_q)
            ST_STREAM: begin
                out_valid      = !empty;
                s.out_data     = empty ? '0 : head_data;
                s.out_msg_last = !empty && head_last && idx_last;
            end
            ST_FILL: begin
                out_valid      = 1'b1;
                s.out_msg_last = idx_last;
            end
            default: ;
        endcase
        xfer = out_valid && s.out_ready;
        pop  = xfer && (state_q == ST_STREAM);
        if (xfer) begin
            idx_d      = idx_last ? '0 : idx_q + IDX_W'(1);
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (idx_last) blk_cnt_d = blk_cnt_q + CNT_W'(1);
            // A message closing before the block boundary pads the block with zero words.
            if (state_q == ST_STREAM && head_last && !idx_last) state_d = ST_FILL;
            if (state_q == ST_FILL && idx_last) state_d = ST_STREAM;
        end
    end

    assign s.out_valid    = out_valid;
    assign s.out_first    = out_valid && (idx_q == '0);
    assign s.out_blk_last = out_valid && idx_last;
    assign word_cnt       = word_cnt_q;
    assign blk_cnt        = blk_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_STREAM;
            idx_q      <= '0;
            word_cnt_q <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_cnt_q <= word_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end
endmodule

// File: tb/tb_sha_word_streamer.sv
// tb/tb_sha_word_streamer.sv - randomized scoreboard bench for sha_word_streamer
module tb_sha_word_streamer;
    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  level;
    logic [31:0] word_cnt, blk_cnt;

    sha_word_streamer_if #(.DATA_W(64)) bus ();

    sha_word_streamer #(.DATA_W(64), .DEPTH(8), .BLOCK_WORDS(BW), .CNT_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (bus.slave),
        .level    (level),
        .word_cnt (word_cnt),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int exp_words = 0;
    int exp_blks = 0;
    bit rand_ready = 1'b0;
    logic [66:0] exp_q[$];
    logic [63:0] held;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output stream: each word tagged with its position in the padded message.
    task automatic model_push(input logic [63:0] d, input logic l);
        exp_q.push_back({d, pos == 0, pos == BW - 1, l && pos == BW - 1});
        pos = (pos + 1) % BW;
        if (l) begin
            while (pos != 0) begin
                exp_q.push_back({64'h0, pos == 0, pos == BW - 1, pos == BW - 1});
                pos = (pos + 1) % BW;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos = 0;
        exp_words = 0;
        exp_blks = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 1, 0);
                end else begin
                    logic [66:0] e;
                    e = exp_q.pop_front();
                    check_eq("out_word", {bus.out_data, bus.out_first, bus.out_blk_last, bus.out_msg_last}, e);
                    exp_words++;
                    if (e[1]) exp_blks++;
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) model_push(bus.in_data, bus.in_last);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        bit acc;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        if (!acc) check_eq("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check_eq("drain", exp_q.size(), 0);
        tick();
        tick();
        check_eq("word_cnt", word_cnt, exp_words);
        check_eq("blk_cnt", blk_cnt, exp_blks);
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hDEAD;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_word_cnt", word_cnt, 0);
        check_eq("rst_blk_cnt", blk_cnt, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_level", level, 0);
        check_eq("post_rst_in_ready", bus.in_ready, 1);
        check_eq("post_rst_out", {bus.out_valid, bus.out_first, bus.out_blk_last, bus.out_msg_last, bus.out_data}, 0);

        for (int i = 1; i <= 8; i++) send_word(64'(i), i == 8);
        drain();
        check_eq("full_blk_words", word_cnt, 8);
        check_eq("full_blk_blks", blk_cnt, 1);

        send_word(64'hA, 0);
        send_word(64'hB, 0);
        send_word(64'hC, 1);
        send_word(64'hD, 1);
        drain();
        check_eq("short_blks", blk_cnt, 3);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(64'h40 + 64'(i), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h48;
        bus.in_last  = 1'b1;
        @(negedge clk);
        check_eq("bp_in_ready", bus.in_ready, 0);
        check_eq("bp_level", level, 8);
        check_eq("bp_head", bus.out_data, 64'h40);
        held = bus.out_data;
        repeat (3) tick();
        check_eq("bp_stable", bus.out_data, held);
        bus.out_ready = 1'b1;
        send_word(64'h48, 1);
        drain();

        bus.out_ready = 1'b0;
        send_word(64'h51, 0);
        send_word(64'h52, 1);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        model_reset();
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_level", level, 0);
        check_eq("midrst_word_cnt", word_cnt, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_word(64'h60 + 64'(i), i == 7);
        drain();

        rand_ready = 1'b1;
        for (int m = 0; m < 100; m++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int w = 0; w < len; w++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_word({$urandom, $urandom}, w == len - 1);
            end
        end
        rand_ready = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
